// File: rtl/uart_digest_tx_ctrl.sv
// uart_digest_tx_ctrl
//   Streams a captured digest out through a single-byte uart_tx block, either
//   as raw bytes or as lowercase ASCII hex (high nibble first), optionally
//   followed by a CR LF trailer. Owns the uart_tx DV/Active/Done handshake.
//
// Ports
//   i_Clock          system clock (shared with uart_tx)
//   i_Rst_n          asynchronous active-low reset
//   i_Digest_Valid   digest offer; accepted when o_Digest_Ready is also high
//   i_Digest         digest, MSB byte sent first
//   o_Digest_Ready   high only while idle
//   o_Tx_DV          one-cycle byte strobe to uart_tx
//   o_Tx_Byte        byte to uart_tx, holds its value between strobes
//   i_Tx_Active      uart_tx frame in progress
//   i_Tx_Done        uart_tx end-of-frame, high for 2 cycles
//   o_Busy           high from capture until o_Send_Done
//   o_Send_Done      one-cycle pulse after the last frame has fully drained
module uart_digest_tx_ctrl #(
  parameter int DIGEST_WIDTH = 256,
  parameter int HEX_MODE     = 1,
  parameter int APPEND_CRLF  = 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Rst_n,
  input  logic                    i_Digest_Valid,
  input  logic [DIGEST_WIDTH-1:0] i_Digest,
  output logic                    o_Digest_Ready,
  output logic                    o_Tx_DV,
  output logic [7:0]              o_Tx_Byte,
  input  logic                    i_Tx_Active,
  input  logic                    i_Tx_Done,
  output logic                    o_Busy,
  output logic                    o_Send_Done
);

  localparam int NBYTES     = DIGEST_WIDTH / 8;
  localparam int DATA_CHARS = (HEX_MODE != 0) ? 2 * NBYTES : NBYTES;
  localparam int N          = DATA_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);

  localparam logic [6:0] LAST     = 7'(N - 1);
  localparam logic [6:0] DATA_END = 7'(DATA_CHARS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_WAIT_GAP,
    S_FINISH
  } state_t;

  state_t                  state;
  logic [6:0]              cnt;
  logic [DIGEST_WIDTH-1:0] shreg;

  logic [7:0] top_byte;
  logic [3:0] nib;
  logic [7:0] cur_char;

  assign o_Digest_Ready = (state == S_IDLE);

  // Current character. In hex mode the count parity picks the nibble: even
  // index = high nibble, odd index = low nibble. Indices past the data are
  // the CR LF trailer.
  always_comb begin
    top_byte = shreg[DIGEST_WIDTH-1 -: 8];
    nib      = cnt[0] ? top_byte[3:0] : top_byte[7:4];
    if (cnt >= DATA_END)
      cur_char = (cnt == DATA_END) ? 8'h0D : 8'h0A;
    else if (HEX_MODE != 0)
      cur_char = (nib < 4'd10) ? {4'h3, nib} : (8'h57 + {4'h0, nib});
    else
      cur_char = top_byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= 8'h00;
      o_Busy      <= 1'b0;
      o_Send_Done <= 1'b0;
    end else begin
      o_Tx_DV     <= 1'b0;
      o_Send_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Digest_Valid) begin
            shreg  <= i_Digest;
            cnt    <= '0;
            o_Busy <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        // Both Active and Done must be low: after a reset uart_tx may still
        // be finishing a frame we no longer track.
        S_ISSUE: begin
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= cur_char;
            state     <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT:  if (i_Tx_Active) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (i_Tx_Done)   state <= S_WAIT_GAP;
        S_WAIT_GAP: begin
          if (!i_Tx_Done) begin
            if (cnt == LAST) begin
              o_Send_Done <= 1'b1;
              o_Busy      <= 1'b0;
              state       <= S_FINISH;
            end else begin
              cnt   <= cnt + 7'd1;
              // hex: the byte is consumed only after its low-nibble character
              if (HEX_MODE == 0 || cnt[0])
                shreg <= shreg << 8;
              state <= S_ISSUE;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
